// File: rtl/cic_i_pkg.sv
// Shared helpers for the CIC interpolator: internal width and rate clamping.
package cic_i_pkg;

   function automatic int clog2_l(input longint unsigned v);
      int             r;
      longint unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

   // W = INP_DW + clog2((R*M)^N / R), shared by every comb and integrator stage.
   function automatic int cic_w(input int inp_dw, input int r, input int n, input int m);
      longint unsigned g;
      g = 1;
      for (int i = 0; i < n; i++) g = g * 64'(r * m);
      return inp_dw + clog2_l(g / 64'(r));
   endfunction

   // 0 and 1 both mean pass-through; anything above the maximum saturates.
   function automatic int unsigned rate_clamp(input int unsigned v, input int unsigned rmax);
      if (v < 2) return 1;
      if (v > rmax) return rmax;
      return v;
   endfunction

endpackage

// File: rtl/comb.sv
// Comb stage y = x - x[-M]; the delay line and output advance only on the strobe.
module comb #(
   parameter int W = 20,
   parameter int M = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   logic [M-1:0][W-1:0] dly;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dly <= '0;
         y   <= '0;
      end else if (en) begin
         y <= x - dly[M-1];
         for (int i = M - 1; i > 0; i--) dly[i] <= dly[i-1];
         dly[0] <= x;
      end
   end

endmodule

// File: rtl/integrator.sv
// Integrator stage y <= y + x; holds its value whenever the input strobe is low.
module integrator #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) y <= '0;
      else if (en)  y <= y + x;
   end

endmodule

// File: rtl/upsampler_variable.sv
// Zero-stuffer: on a strobe emits the sample, then rate-1 zeros, all with valid high.
module upsampler_variable #(
   parameter int W       = 20,
   parameter int RATE_DW = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_vld,
   input  logic [W-1:0]       in_data,
   input  logic [RATE_DW-1:0] in_rate,
   output logic               out_vld,
   output logic [W-1:0]       out_data
);

   logic [RATE_DW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (in_vld) begin
         cnt      <= in_rate - RATE_DW'(1);
         out_vld  <= 1'b1;
         out_data <= in_data;
      end else if (cnt != '0) begin
         cnt      <= cnt - RATE_DW'(1);
         out_vld  <= 1'b1;
         out_data <= '0;
      end else begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end
   end

endmodule

// File: rtl/cic_i.sv
// Variable-rate CIC interpolator: combs at input rate, zero-stuff by R, integrators at output rate.
module cic_i
   import cic_i_pkg::*;
#(
   parameter int INP_DW        = 18,
   parameter int OUT_DW        = 18,
   parameter int CIC_R         = 10,
   parameter int CIC_N         = 7,
   parameter int CIC_M         = 1,
   parameter int VARIABLE_RATE = 1,
   parameter int RATE_DW       = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [INP_DW-1:0]  s_axis_in_tdata,
   input  logic               s_axis_in_tvalid,
   output logic               s_axis_in_tready,
   input  logic [RATE_DW-1:0] s_axis_rate_tdata,
   input  logic               s_axis_rate_tvalid,
   output logic [OUT_DW-1:0]  m_axis_out_tdata,
   output logic               m_axis_out_tvalid
);

   localparam int W = cic_w(INP_DW, CIC_R, CIC_N, CIC_M);

   logic [RATE_DW-1:0]          rate_q, in_cnt, in_cnt_nxt;
   logic                        in_rdy_q, hs;
   logic [W-1:0]                in_d;
   logic [CIC_N:0]              vld_pipe;
   logic [CIC_N:0][RATE_DW-1:0] rs_pipe;
   logic [CIC_N:0][W-1:0]       comb_d;
   logic                        up_vld;
   logic [CIC_N-1:0]            ivld_q;
   logic [CIC_N:0]              ivld;
   logic [CIC_N:0][W-1:0]       int_d;
   logic                        unused_lsb;

   if (VARIABLE_RATE != 0) begin : g_var_rate
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            rate_q <= RATE_DW'(CIC_R);
         else if (s_axis_rate_tvalid)
            rate_q <= RATE_DW'(rate_clamp(32'(s_axis_rate_tdata), 32'(CIC_R)));
      end
   end else begin : g_fix_rate
      logic unused_rate;
      assign unused_rate = ^{s_axis_rate_tdata, s_axis_rate_tvalid};
      assign rate_q      = RATE_DW'(CIC_R);
   end

   // One sample per rate_q cycles; the rate in force at the handshake rides with it.
   assign hs               = s_axis_in_tvalid & in_rdy_q;
   assign s_axis_in_tready = in_rdy_q;
   assign in_cnt_nxt       = hs ? rate_q - RATE_DW'(1) :
                             (in_cnt != '0) ? in_cnt - RATE_DW'(1) : in_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_cnt   <= '0;
         in_rdy_q <= 1'b0;
         in_d     <= '0;
         vld_pipe <= '0;
         rs_pipe  <= '0;
         ivld_q   <= '0;
      end else begin
         in_cnt   <= in_cnt_nxt;
         in_rdy_q <= (in_cnt_nxt == '0);
         if (hs) in_d <= W'($signed(s_axis_in_tdata));
         vld_pipe <= {vld_pipe[CIC_N-1:0], hs};
         rs_pipe  <= {rs_pipe[CIC_N-1:0], rate_q};
         ivld_q   <= ivld[CIC_N-1:0];
      end
   end

   assign comb_d[0] = in_d;

   for (genvar k = 0; k < CIC_N; k++) begin : g_comb
      comb #(.W(W), .M(CIC_M)) u_comb (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (vld_pipe[k]),
         .x       (comb_d[k]),
         .y       (comb_d[k+1])
      );
   end

   upsampler_variable #(.W(W), .RATE_DW(RATE_DW)) u_up (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_vld   (vld_pipe[CIC_N]),
      .in_data  (comb_d[CIC_N]),
      .in_rate  (rs_pipe[CIC_N]),
      .out_vld  (up_vld),
      .out_data (int_d[0])
   );

   assign ivld = {ivld_q, up_vld};

   for (genvar k = 0; k < CIC_N; k++) begin : g_int
      integrator #(.W(W)) u_int (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (ivld[k]),
         .x       (int_d[k]),
         .y       (int_d[k+1])
      );
   end

   assign m_axis_out_tdata  = int_d[CIC_N][W-1 -: OUT_DW];
   assign m_axis_out_tvalid = ivld[CIC_N];
   assign unused_lsb        = ^int_d[CIC_N];

endmodule

// File: tb/tb_cic_i.sv
// Directed bench for cic_i at INP_DW=16, N=3, R=4, M=1 (W=20, full-width output).
module tb_cic_i;

   localparam int INP_DW = 16;
   localparam int OUT_DW = 20;
   localparam int RATE_DW = 16;

   logic                      clk = 1'b0;
   logic                      reset_n = 1'b0;
   logic signed [INP_DW-1:0]  in_data = '0;
   logic                      in_vld = 1'b0;
   logic                      in_rdy;
   logic [RATE_DW-1:0]        rate_data = '0;
   logic                      rate_vld = 1'b0;
   logic signed [OUT_DW-1:0]  out_data;
   logic                      out_vld;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int out_q[$];
   int out_cyc_q[$];
   int hs_q[$];

   cic_i #(
      .INP_DW(INP_DW), .OUT_DW(OUT_DW), .CIC_R(4), .CIC_N(3), .CIC_M(1),
      .VARIABLE_RATE(1), .RATE_DW(RATE_DW)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .s_axis_in_tdata    (in_data),
      .s_axis_in_tvalid   (in_vld),
      .s_axis_in_tready   (in_rdy),
      .s_axis_rate_tdata  (rate_data),
      .s_axis_rate_tvalid (rate_vld),
      .m_axis_out_tdata   (out_data),
      .m_axis_out_tvalid  (out_vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Cycle stamps taken mid-cycle: a handshake stamp is the cycle whose edge captures it.
   always @(negedge clk) begin
      if (reset_n && out_vld) begin
         out_q.push_back(int'(out_data));
         out_cyc_q.push_back(cyc);
      end
      if (reset_n && in_vld && in_rdy) hs_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ncyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [INP_DW-1:0] d);
      int w;
      in_data = d;
      in_vld  = 1'b1;
      w = 0;
      @(negedge clk);
      while (in_rdy !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      chk("send_ready", in_rdy, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic set_rate(input int r);
      rate_data = RATE_DW'(r);
      rate_vld  = 1'b1;
      @(posedge clk);
      #1;
      rate_vld  = 1'b0;
   endtask

   // 20-cycle window: output valid every cycle at exp_val, and exp_rdy ready cycles.
   task automatic window(input string tag, input int exp_val, input int exp_rdy);
      int bad, rdy;
      bad = 0;
      rdy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_vld !== 1'b1 || int'(out_data) != exp_val) bad++;
         if (in_rdy === 1'b1) rdy++;
      end
      chk({tag, "_level"}, int'(out_data), exp_val);
      chk({tag, "_gaps"}, bad, 0);
      chk({tag, "_rdy"}, rdy, exp_rdy);
   endtask

   // Impulse response of (1-z^-4)^3/(1-z^-1)^3 zero-stuffed at R=4.
   task automatic impulse(input string tag);
      int exp_imp[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
      out_q.delete();
      out_cyc_q.delete();
      hs_q.delete();
      send(1);
      repeat (12) send(0);
      in_vld = 1'b0;
      ncyc(30);
      chk({tag, "_hs_count"}, hs_q.size(), 13);
      chk({tag, "_out_count"}, out_q.size(), 52);
      chk({tag, "_latency"}, out_cyc_q[0] - hs_q[0], 8);
      chk({tag, "_burst_span"}, out_cyc_q[9] - out_cyc_q[0], 9);
      for (int i = 0; i < 20; i++)
         chk({tag, "_val"}, out_q[i], (i < 10) ? exp_imp[i] : 0);
   endtask

   initial begin
      int bad;

      #2;
      chk("rst_tvalid", out_vld, 0);
      chk("rst_tdata", out_data, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_tready", in_rdy, 1);
      chk("rst_rate", int'(dut.rate_q), 4);

      impulse("imp");

      // DC from rest at R=4: gain R^(N-1) = 16.
      @(posedge clk); #1;
      in_data = 1000;
      in_vld  = 1'b1;
      ncyc(80);
      window("dc4", 16000, 5);
      @(posedge clk); #1;
      in_data = 0;
      ncyc(80);
      chk("dc4_return", out_data, 0);

      // Once a DC stream has settled the combs emit zeros, so a new rate only shows
      // in the level when the stream is restarted from rest.
      set_rate(2);
      ncyc(20);
      window("zero2", 0, 10);
      @(posedge clk); #1;
      in_data = 1000;
      ncyc(80);
      window("dc2", 4000, 10);
      @(posedge clk); #1;
      in_data = 0;
      ncyc(80);
      chk("dc2_return", out_data, 0);

      set_rate(0);
      ncyc(20);
      in_data = 1000;
      ncyc(60);
      window("dc1", 1000, 20);
      @(posedge clk); #1;
      in_data = 0;
      ncyc(60);
      chk("dc1_return", out_data, 0);

      set_rate(9);
      ncyc(20);
      window("zero4", 0, 5);
      chk("rate_clamp_hi", int'(dut.rate_q), 4);

      // Starvation: output stops after the in-flight burst and resumes without a glitch.
      @(posedge clk); #1;
      in_data = 1000;
      ncyc(80);
      window("dc4b", 16000, 5);
      @(posedge clk); #1;
      in_vld = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i >= 14 && out_vld !== 1'b0) bad++;
         if (int'(out_data) != 16000) bad++;
      end
      chk("starve_quiet", bad, 0);
      @(posedge clk); #1;
      out_q.delete();
      out_cyc_q.delete();
      hs_q.delete();
      in_vld = 1'b1;
      ncyc(30);
      chk("resume_latency", out_cyc_q[0] - hs_q[0], 8);
      chk("resume_first", out_q[0], 16000);
      bad = 0;
      foreach (out_q[i]) if (out_q[i] != 16000) bad++;
      chk("resume_glitch", bad, 0);

      // Reset in the middle of a burst, with a non-default rate loaded.
      set_rate(2);
      ncyc(10);
      chk("pre_reset_vld", out_vld, 1);
      #2;
      reset_n = 1'b0;
      in_vld  = 1'b0;
      #1;
      chk("mid_rst_tvalid", out_vld, 0);
      chk("mid_rst_tdata", out_data, 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_tready", in_rdy, 1);
      chk("post_rst_rate", int'(dut.rate_q), 4);

      impulse("imp2");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
